// File: rtl/elevator_request_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_request_scheduler
//
// Latches per-floor call buttons into a pending-request bitmap and selects
// the next floor to serve with a directional (SCAN) sweep. The selected
// floor is handed to the downstream motor/door controller on floor_request,
// and a request is retired when the controller reports door_open at it.
// A car sweeping in one direction is never retargeted behind itself; a
// new request between the car and its target, ahead of it, pulls the
// target in to the nearer floor.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high; clears all state
//   call_btn       per-floor call buttons (bit i = floor i), level or pulse
//   current_floor  floor the car is at or passing
//   door_open      one-cycle pulse when the door opens at current_floor
//   floor_request  registered target floor for the controller
//   request_valid  registered; high while any request is pending
//   pending        registered pending-request bitmap
//   dir_up         registered; sweeping upward
//   dir_down       registered; sweeping downward
// ---------------------------------------------------------------------------
module elevator_request_scheduler #(
    parameter int FLOOR_W    = 2,
    parameter int NUM_FLOORS = 2 ** FLOOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    output logic [FLOOR_W-1:0]    floor_request,
    output logic                  request_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  dir_down
);

    typedef enum logic [1:0] {
        SCH_IDLE = 2'd0,
        SCH_UP   = 2'd1,
        SCH_DOWN = 2'd2
    } sch_state_t;

    sch_state_t state;

    logic [NUM_FLOORS-1:0] clr;
    logic                  here;
    logic                  above_any;
    logic [FLOOR_W-1:0]    above_low;
    logic                  below_any;
    logic [FLOOR_W-1:0]    below_high;

    // Retire the request at the floor where the door just opened. A press
    // at that floor in the same cycle is dropped because clear is applied
    // after the OR.
    assign clr  = door_open ? (NUM_FLOORS'(1) << current_floor) : '0;
    assign here = pending[current_floor];

    // Nearest pending floor strictly above and strictly below the car,
    // derived from the registered bitmap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first
        // so no path leaves it unassigned, which would infer a latch.
        above_any  = 1'b0;
        above_low  = '0;
        below_any  = 1'b0;
        below_high = '0;
        // Descending scan: the last hit is the lowest index above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                above_any = 1'b1;
                above_low = FLOOR_W'(i);
            end
        end
        // Ascending scan: the last hit is the highest index below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                below_any  = 1'b1;
                below_high = FLOOR_W'(i);
            end
        end
    end

    // State, target and all outputs are registered together so the
    // controller sees a consistent (floor_request, dir_*) pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments throughout sequential logic so
            // every register samples the pre-edge values of the others.
            state         <= SCH_IDLE;
            pending       <= '0;
            floor_request <= '0;
            request_valid <= 1'b0;
            dir_up        <= 1'b0;
            dir_down      <= 1'b0;
        end else begin
            pending       <= (pending | call_btn) & ~clr;
            request_valid <= |pending;

            case (state)
                SCH_UP: begin
                    // at_or_above: the current floor counts as "ahead".
                    if (here || above_any) begin
                        state         <= SCH_UP;
                        floor_request <= here ? current_floor : above_low;
                    end else if (below_any) begin
                        state         <= SCH_DOWN;
                        floor_request <= below_high;
                    end else begin
                        state         <= SCH_IDLE;
                        floor_request <= current_floor;
                    end
                end
                SCH_DOWN: begin
                    if (here || below_any) begin
                        state         <= SCH_DOWN;
                        floor_request <= here ? current_floor : below_high;
                    end else if (above_any) begin
                        state         <= SCH_UP;
                        floor_request <= above_low;
                    end else begin
                        state         <= SCH_IDLE;
                        floor_request <= current_floor;
                    end
                end
                default: begin
                    // Idle prefers serving the current floor, then upward.
                    if (here) begin
                        state         <= SCH_IDLE;
                        floor_request <= current_floor;
                    end else if (above_any) begin
                        state         <= SCH_UP;
                        floor_request <= above_low;
                    end else if (below_any) begin
                        state         <= SCH_DOWN;
                        floor_request <= below_high;
                    end else begin
                        state         <= SCH_IDLE;
                        floor_request <= current_floor;
                    end
                end
            endcase

            // Direction flags mirror the state being entered this edge.
            dir_up   <= 1'b0;
            dir_down <= 1'b0;
            case (state)
                SCH_UP: begin
                    if (here || above_any) dir_up   <= 1'b1;
                    else if (below_any)    dir_down <= 1'b1;
                end
                SCH_DOWN: begin
                    if (here || below_any) dir_down <= 1'b1;
                    else if (above_any)    dir_up   <= 1'b1;
                end
                default: begin
                    if (!here && above_any)                   dir_up   <= 1'b1;
                    else if (!here && !above_any && below_any) dir_down <= 1'b1;
                end
            endcase
        end
    end

endmodule
